seq_right_shifter: RTL and testbench

- Sequential right shifter, the counterpart of the team's combinational left shifter: left shift multiplies by 2^n, this block divides by 2^n.
- It loads a word and a shift amount, then shifts right one bit per clock, logical or arithmetic.
- It reports completion and a sticky bit for the bits shifted out (rounding/remainder indication).
- Used by datapath blocks that need divide-by-2^n without a full barrel shifter.

---
 rtl/shifter_pkg.sv | 30 +++
 rtl/seq_right_shifter_if.sv | 35 +++
 rtl/seq_right_shifter.sv | 109 ++++++++++
 tb/tb_seq_right_shifter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential right shifter.
// Contents:
//   state_t      - controller states (IDLE, SHIFT, DONE)
//   clog2()      - constant ceil(log2) used to size the shift-amount port
//   FILL_LOGICAL - mode encoding: vacated MSBs are filled with zero
//   FILL_ARITH   - mode encoding: vacated MSBs replicate the sign bit
package shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic FILL_LOGICAL = 1'b0;
    localparam logic FILL_ARITH   = 1'b1;

    // Smallest r with 2**r >= v; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_right_shifter_if.sv
// Request/result bundle of the sequential right shifter.
// Handshake: a request is taken when start=1 at a rising edge while the
// block is idle (busy=0); start while busy=1 is dropped. Completion is the
// one-cycle done pulse; Q/sticky/shift_out are final while done=1 and are
// held afterwards until the next accepted request.
// Signals:
//   start, D, amt, arith       - request (master -> slave)
//   Q, busy, done, sticky,
//   shift_out                  - result/status (slave -> master)
interface seq_right_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = clog2(WIDTH) + 1
);
    logic             start;
    logic [WIDTH-1:0] D;
    logic [AMT_W-1:0] amt;
    logic             arith;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             done;
    logic             sticky;
    logic             shift_out;

    modport master (
        output start, D, amt, arith,
        input  Q, busy, done, sticky, shift_out
    );

    modport slave (
        input  start, D, amt, arith,
        output Q, busy, done, sticky, shift_out
    );
endinterface

// File: rtl/seq_right_shifter.sv
// Sequential right shifter: divides a word by 2^n, one bit position per
// clock, with zero fill (logical) or sign fill (arithmetic). Reports the
// last bit shifted out and a sticky OR of all bits shifted out.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous, active-high reset
//   bus        - request/result bundle (slave side)
//   state_dbg  - current controller state, for observation only
module seq_right_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_right_shifter_if.slave   bus,
    output state_t               state_dbg
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             sticky_q, sticky_d;
    logic             shift_out_q, shift_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [AMT_W-1:0] amt_sat;
    logic             fill;

    // Shifting more than WIDTH places cannot change the result any further,
    // so the count saturates at WIDTH.
    assign amt_sat = (bus.amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.amt;
    assign fill    = (mode_q == FILL_ARITH) ? q_q[WIDTH-1] : 1'b0;

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        sticky_d    = sticky_q;
        shift_out_d = shift_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d         = bus.D;
                    cnt_d       = amt_sat;
                    mode_d      = bus.arith ? FILL_ARITH : FILL_LOGICAL;
                    sticky_d    = 1'b0;
                    shift_out_d = 1'b0;
                    state_d     = (amt_sat == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                q_d         = {fill, q_q[WIDTH-1:1]};
                shift_out_d = q_q[0];
                sticky_d    = sticky_q | q_q[0];
                cnt_d       = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they come
        // straight out of flops, aligned with the state they describe.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            cnt_q       <= '0;
            mode_q      <= FILL_LOGICAL;
            sticky_q    <= 1'b0;
            shift_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            sticky_q    <= sticky_d;
            shift_out_q <= shift_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sticky    = sticky_q;
    assign bus.shift_out = shift_out_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Testbench for seq_right_shifter: directed vectors, expected results
// queued by the driver and checked by an independent done monitor.
module tb_seq_right_shifter;
    import shifter_pkg::*;

    localparam int WIDTH = 4;
    localparam int AMT_W = clog2(WIDTH) + 1;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst;
    state_t state_dbg;

    always #5 clk = ~clk;

    seq_right_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    seq_right_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH+1:0] exp_q[$];   // {Q, sticky, shift_out}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                logic [WIDTH+1:0] e;
                e = exp_q.pop_front();
                check("result{Q,sticky,shift_out}", {bus.Q, bus.sticky, bus.shift_out}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // poke: bit i set -> drive a competing start (D=1111) in the i-th
    // cycle after acceptance; it must be ignored.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                          input logic ar, input logic [WIDTH-1:0] eq,
                          input logic es, input logic eso, input int elat,
                          input int mid_lat, input logic [WIDTH-1:0] mid_q,
                          input logic [7:0] poke);
        bit seen;
        int busy_n;
        exp_q.push_back({eq, es, eso});
        @(negedge clk);
        bus.start = 1'b1;
        bus.D     = d;
        bus.amt   = a;
        bus.arith = ar;
        seen   = 0;
        busy_n = 0;
        for (int lat = 1; lat <= 20 && !seen; lat++) begin
            @(negedge clk);
            if (lat < 8 && poke[lat]) begin
                bus.start = 1'b1;
                bus.D     = 4'b1111;
                bus.amt   = 3'd1;
                bus.arith = 1'b1;
            end else begin
                // Scramble operands while busy; they must not matter.
                bus.start = 1'b0;
                bus.D     = ~d;
                bus.amt   = 3'd0;
                bus.arith = ~ar;
            end
            if (bus.busy === 1'b1) busy_n++;
            if (mid_lat == lat) check("intermediate_Q", bus.Q, mid_q);
            if (bus.done === 1'b1) begin
                seen = 1;
                check("latency", lat, elat);
                check("busy_cycles", busy_n, elat);
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done in 20 cycles expected done after %0d", elat);
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("done_one_cycle", bus.done, 1'b0);
        check("busy_back_low", bus.busy, 1'b0);
        check("Q_held_in_idle", bus.Q, eq);
    endtask

    task automatic reset_mid_shift();
        bit seen_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.D     = 4'b1111;
        bus.amt   = 3'd4;
        bus.arith = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("mid_state_shift", state_dbg, SHIFT);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", state_dbg, IDLE);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_Q", bus.Q, 4'b0000);
        check("abort_sticky", bus.sticky, 1'b0);
        rst = 1'b0;
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1;
        end
        check("no_done_after_abort", seen_done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.D     = '0;
        bus.amt   = '0;
        bus.arith = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_Q", bus.Q, 4'b0000);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_sticky", bus.sticky, 1'b0);
        check("reset_shift_out", bus.shift_out, 1'b0);
        check("reset_state", state_dbg, IDLE);
        rst = 1'b0;

        //      D        amt   ar    Q        st    so    lat mid mid_q    poke
        run_op(4'b1011, 3'd2, 1'b0, 4'b0010, 1'b1, 1'b1, 3,  2, 4'b0101, 8'h00);
        run_op(4'b1000, 3'd3, 1'b1, 4'b1111, 1'b0, 1'b0, 4,  2, 4'b1100, 8'h00);
        run_op(4'b0110, 3'd0, 1'b0, 4'b0110, 1'b0, 1'b0, 1,  0, 4'b0000, 8'h00);
        run_op(4'b1111, 3'd7, 1'b0, 4'b0000, 1'b1, 1'b1, 5,  0, 4'b0000, 8'h00);
        run_op(4'b1111, 3'd7, 1'b1, 4'b1111, 1'b1, 1'b1, 5,  0, 4'b0000, 8'h00);
        run_op(4'b1001, 3'd4, 1'b1, 4'b1111, 1'b1, 1'b1, 5,  0, 4'b0000, 8'h00);
        run_op(4'b0101, 3'd3, 1'b0, 4'b0000, 1'b1, 1'b1, 4,  1, 4'b0101, 8'h00);
        // Competing starts in SHIFT (cycle 1) and DONE (cycle 3).
        run_op(4'b0001, 3'd2, 1'b0, 4'b0000, 1'b1, 1'b0, 3,  0, 4'b0000, 8'h0A);
        run_op(4'b0110, 3'd1, 1'b0, 4'b0011, 1'b0, 1'b0, 2,  0, 4'b0000, 8'h00);

        reset_mid_shift();

        run_op(4'b1010, 3'd1, 1'b1, 4'b1101, 1'b0, 1'b0, 2,  0, 4'b0000, 8'h00);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
